// File: rtl/ram_arbiter_pkg.sv
// Shared constants for the two-master RAM arbiter: bus width, arbitration modes
// and requester identifiers.
package ram_arbiter_pkg;

   localparam int DATA_WIDTH = 32;

   localparam int ARB_ROUND_ROBIN = 0;
   localparam int ARB_FIXED       = 1;

   localparam logic REQ_ID_CORE = 1'b0;
   localparam logic REQ_ID_AUX  = 1'b1;

endpackage

// File: rtl/ram_arbiter_pick.sv
// Combinational winner selection: bus lock first, then the sole requester,
// then round-robin or fixed priority.
module arbiter_pick #(
   parameter int MAX_LOCK_CYCLES = 8,
   parameter int COUNT_W         = $clog2(MAX_LOCK_CYCLES + 1)
) (
   input  logic [1:0]         valid,
   input  logic               lastGrant,
   input  logic               lockActive,
   input  logic               lockOwner,
   input  logic [COUNT_W-1:0] lockCount,
   input  logic               fixedPriority,
   output logic               winner,
   output logic               idle,
   output logic               lockBreak
);
   import ram_arbiter_pkg::*;

   localparam logic [COUNT_W-1:0] MAX_COUNT = COUNT_W'(MAX_LOCK_CYCLES);

   logic lockLive;

   always_comb begin
      winner    = REQ_ID_CORE;
      idle      = 1'b0;
      lockBreak = 1'b0;
      lockLive  = lockActive && valid[lockOwner];
      if (lockLive && (lockCount < MAX_COUNT)) begin
         winner = lockOwner;
      end else begin
         // A live lock that reached its budget yields to one normal arbitration.
         lockBreak = lockLive;
         case (valid)
            2'b01:   winner = REQ_ID_CORE;
            2'b10:   winner = REQ_ID_AUX;
            2'b11:   winner = fixedPriority ? REQ_ID_CORE : ~lastGrant;
            default: idle   = 1'b1;
         endcase
      end
   end

endmodule

// File: rtl/ram_arbiter.sv
// Shares the single-ported main RAM between the core memory port (requester 0)
// and an auxiliary master (requester 1); routes one-cycle read data back.
module ram_arbiter #(
   parameter int DATA_WIDTH      = ram_arbiter_pkg::DATA_WIDTH,
   parameter int PRIORITY_MODE   = ram_arbiter_pkg::ARB_ROUND_ROBIN,
   parameter int MAX_LOCK_CYCLES = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req0_valid,
   input  logic                  req0_store,
   input  logic [DATA_WIDTH-1:0] req0_address,
   input  logic [DATA_WIDTH-1:0] req0_dataWrite,
   input  logic [3:0]            req0_byteSelect,
   input  logic                  req0_lock,
   output logic                  req0_grant,
   output logic                  req0_readValid,
   output logic [DATA_WIDTH-1:0] req0_dataRead,
   input  logic                  req1_valid,
   input  logic                  req1_store,
   input  logic [DATA_WIDTH-1:0] req1_address,
   input  logic [DATA_WIDTH-1:0] req1_dataWrite,
   input  logic [3:0]            req1_byteSelect,
   input  logic                  req1_lock,
   output logic                  req1_grant,
   output logic                  req1_readValid,
   output logic [DATA_WIDTH-1:0] req1_dataRead,
   input  logic [DATA_WIDTH-1:0] ramDataRead,
   output logic [DATA_WIDTH-1:0] addressOut,
   output logic [DATA_WIDTH-1:0] ramDataWrite,
   output logic [3:0]            byteSelect,
   output logic                  ramStore,
   output logic                  ramLoad
);
   import ram_arbiter_pkg::*;

   localparam int COUNT_W = $clog2(MAX_LOCK_CYCLES + 1);

   logic               lastGrant;
   logic               lockActive;
   logic               lockOwner;
   logic [COUNT_W-1:0] lockCount;
   logic               readPending;
   logic               readOwner;

   logic                  winner;
   logic                  idle;
   logic                  lockBreak;
   logic                  issue;
   logic                  winStore;
   logic                  winLock;
   logic [DATA_WIDTH-1:0] winAddress;
   logic [DATA_WIDTH-1:0] winData;
   logic [3:0]            winByteSelect;

   arbiter_pick #(
      .MAX_LOCK_CYCLES(MAX_LOCK_CYCLES),
      .COUNT_W        (COUNT_W)
   ) u_pick (
      .valid        ({req1_valid, req0_valid}),
      .lastGrant    (lastGrant),
      .lockActive   (lockActive),
      .lockOwner    (lockOwner),
      .lockCount    (lockCount),
      .fixedPriority(PRIORITY_MODE == ARB_FIXED),
      .winner       (winner),
      .idle         (idle),
      .lockBreak    (lockBreak)
   );

   assign issue         = ~idle & ~reset;
   assign winStore      = winner ? req1_store      : req0_store;
   assign winLock       = winner ? req1_lock       : req0_lock;
   assign winAddress    = winner ? req1_address    : req0_address;
   assign winData       = winner ? req1_dataWrite  : req0_dataWrite;
   assign winByteSelect = winner ? req1_byteSelect : req0_byteSelect;

   always_comb begin
      req0_grant   = 1'b0;
      req1_grant   = 1'b0;
      addressOut   = '0;
      ramDataWrite = '0;
      byteSelect   = 4'b0000;
      ramStore     = 1'b0;
      ramLoad      = 1'b0;
      if (issue) begin
         req0_grant   = (winner == REQ_ID_CORE);
         req1_grant   = (winner == REQ_ID_AUX);
         addressOut   = winAddress;
         ramDataWrite = winData;
         byteSelect   = winStore ? winByteSelect : 4'b0000;
         ramStore     = winStore;
         ramLoad      = ~winStore;
      end
   end

   // The RAM registers its read, so data arrives the cycle after the load strobe.
   assign req0_readValid = readPending && (readOwner == REQ_ID_CORE);
   assign req1_readValid = readPending && (readOwner == REQ_ID_AUX);
   assign req0_dataRead  = ramDataRead;
   assign req1_dataRead  = ramDataRead;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lastGrant   <= REQ_ID_AUX;
         lockActive  <= 1'b0;
         lockOwner   <= REQ_ID_CORE;
         lockCount   <= '0;
         readPending <= 1'b0;
         readOwner   <= REQ_ID_CORE;
      end else begin
         readPending <= issue & ~winStore;
         if (issue) begin
            lastGrant <= winner;
            if (!winStore) readOwner <= winner;
         end
         if (lockBreak) begin
            lockActive <= 1'b0;
            lockCount  <= '0;
         end else if (issue && winLock) begin
            lockActive <= 1'b1;
            lockOwner  <= winner;
            lockCount  <= (lockActive && lockOwner == winner) ? lockCount + COUNT_W'(1)
                                                              : COUNT_W'(1);
         end else begin
            lockActive <= 1'b0;
            lockCount  <= '0;
         end
      end
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: behavioural one-cycle RAM, read-return
// scoreboard, request-hold protocol monitor and a fixed-priority second instance.
module tb_ram_arbiter;

   logic clk = 1'b0;
   logic reset;

   logic        req0_valid, req0_store, req0_lock;
   logic [31:0] req0_address, req0_dataWrite;
   logic [3:0]  req0_byteSelect;
   logic        req1_valid, req1_store, req1_lock;
   logic [31:0] req1_address, req1_dataWrite;
   logic [3:0]  req1_byteSelect;

   logic        req0_grant, req0_readValid, req1_grant, req1_readValid;
   logic [31:0] req0_dataRead, req1_dataRead;
   logic [31:0] ramDataRead;
   logic [31:0] addressOut, ramDataWrite;
   logic [3:0]  byteSelect;
   logic        ramStore, ramLoad;

   logic        fx_req0_grant, fx_req0_readValid, fx_req1_grant, fx_req1_readValid;
   logic [31:0] fx_req0_dataRead, fx_req1_dataRead, fx_addressOut, fx_ramDataWrite;
   logic [3:0]  fx_byteSelect;
   logic        fx_ramStore, fx_ramLoad;

   logic [31:0] mem [0:63];
   logic [32:0] exp_q [$];
   int          n_checks = 0;
   int          n_errors = 0;
   logic        fixed_mode = 1'b0;
   logic [1:0]  pend = 2'b00;

   ram_arbiter #(.DATA_WIDTH(32), .PRIORITY_MODE(0), .MAX_LOCK_CYCLES(8)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_store(req0_store), .req0_address(req0_address),
      .req0_dataWrite(req0_dataWrite), .req0_byteSelect(req0_byteSelect), .req0_lock(req0_lock),
      .req0_grant(req0_grant), .req0_readValid(req0_readValid), .req0_dataRead(req0_dataRead),
      .req1_valid(req1_valid), .req1_store(req1_store), .req1_address(req1_address),
      .req1_dataWrite(req1_dataWrite), .req1_byteSelect(req1_byteSelect), .req1_lock(req1_lock),
      .req1_grant(req1_grant), .req1_readValid(req1_readValid), .req1_dataRead(req1_dataRead),
      .ramDataRead(ramDataRead), .addressOut(addressOut), .ramDataWrite(ramDataWrite),
      .byteSelect(byteSelect), .ramStore(ramStore), .ramLoad(ramLoad)
   );

   ram_arbiter #(.DATA_WIDTH(32), .PRIORITY_MODE(1), .MAX_LOCK_CYCLES(8)) fx (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_store(req0_store), .req0_address(req0_address),
      .req0_dataWrite(req0_dataWrite), .req0_byteSelect(req0_byteSelect), .req0_lock(req0_lock),
      .req0_grant(fx_req0_grant), .req0_readValid(fx_req0_readValid), .req0_dataRead(fx_req0_dataRead),
      .req1_valid(req1_valid), .req1_store(req1_store), .req1_address(req1_address),
      .req1_dataWrite(req1_dataWrite), .req1_byteSelect(req1_byteSelect), .req1_lock(req1_lock),
      .req1_grant(fx_req1_grant), .req1_readValid(fx_req1_readValid), .req1_dataRead(fx_req1_dataRead),
      .ramDataRead(ramDataRead), .addressOut(fx_addressOut), .ramDataWrite(fx_ramDataWrite),
      .byteSelect(fx_byteSelect), .ramStore(fx_ramStore), .ramLoad(fx_ramLoad)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   function automatic logic [31:0] exp_word(input logic [31:0] a);
      return (a == 32'h10) ? 32'hDEADBEEF : {16'hC0DE, a[15:0]};
   endfunction

   // ---------------- RAM model (registered read) ----------------
   initial begin
      ramDataRead = 32'h0;
      for (int i = 0; i < 64; i++) mem[i] = exp_word(32'(i * 4));
   end

   always @(posedge clk) begin
      if (ramStore)
         for (int b = 0; b < 4; b++)
            if (byteSelect[b]) mem[addressOut[7:2]][8*b +: 8] <= ramDataWrite[8*b +: 8];
      if (ramLoad) ramDataRead <= mem[addressOut[7:2]];
   end

   // ---------------- checks ----------------
   task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // A request seen pending without a grant must still be valid next cycle.
   always @(negedge clk) begin
      if (reset) begin
         pend = 2'b00;
      end else begin
         for (int n = 0; n < 2; n++) begin
            if (pend[n]) begin
               n_checks++;
               assert ((n == 0 ? req0_valid : req1_valid) === 1'b1) else begin
                  n_errors++;
                  $error("FAIL proto_hold req%0d observed=0 expected=1", n);
               end
            end
         end
         pend = {req1_valid, req0_valid} &
                ~(fixed_mode ? {fx_req1_grant, fx_req0_grant} : {req1_grant, req0_grant});
      end
   end

   task automatic check_returns(input string tag);
      logic [32:0] e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check({tag, "_rv"}, 96'({req1_readValid, req0_readValid}), e[32] ? 96'd2 : 96'd1);
         check({tag, "_rdata"}, 96'(e[32] ? req1_dataRead : req0_dataRead), 96'(e[31:0]));
      end else begin
         check({tag, "_rv"}, 96'({req1_readValid, req0_readValid}), 96'd0);
      end
   endtask

   // One cycle: check returns, grants and RAM drive, queue expected load data.
   task automatic cycle(input logic [1:0] exp_grant, input string tag);
      logic        w, st;
      logic [31:0] a, d;
      logic [3:0]  bs;
      logic [69:0] exp_ram;
      @(negedge clk);
      check_returns(tag);
      check({tag, "_grant"}, 96'({req1_grant, req0_grant}), 96'(exp_grant));
      exp_ram = '0;
      if (exp_grant != 2'b00) begin
         w  = exp_grant[1];
         st = w ? req1_store      : req0_store;
         a  = w ? req1_address    : req0_address;
         d  = w ? req1_dataWrite  : req0_dataWrite;
         bs = w ? req1_byteSelect : req0_byteSelect;
         exp_ram = {st, ~st, a, d, st ? bs : 4'b0000};
         if (!st) exp_q.push_back({w, exp_word(a)});
      end
      check({tag, "_ram"}, 96'({ramStore, ramLoad, addressOut, ramDataWrite, byteSelect}),
            96'(exp_ram));
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut();
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      exp_q.delete();
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      reset = 1'b1;
      req0_valid = 0; req0_store = 0; req0_lock = 0; req0_address = 0;
      req0_dataWrite = 0; req0_byteSelect = 0;
      req1_valid = 0; req1_store = 0; req1_lock = 0; req1_address = 0;
      req1_dataWrite = 0; req1_byteSelect = 0;

      @(negedge clk);
      check("rst_grant", 96'({req1_grant, req0_grant}), 96'd0);
      check("rst_rv", 96'({req1_readValid, req0_readValid}), 96'd0);
      check("rst_ram", 96'({ramStore, ramLoad, addressOut, ramDataWrite, byteSelect}), 96'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // 1: reset while a load is pending
      req0_valid = 1; req0_store = 0; req0_address = 32'h10;
      cycle(2'b01, "t1_load");
      req0_valid = 0;
      reset = 1'b1;
      @(negedge clk);
      check("t1_rv_in_reset", 96'({req1_readValid, req0_readValid}), 96'd0);
      check("t1_strobe_in_reset", 96'({ramStore, ramLoad}), 96'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      exp_q.delete();
      cycle(2'b00, "t1_after");

      // 2: round-robin loads, both requesters continuously valid
      reset_dut();
      req0_valid = 1; req0_store = 0; req0_address = 32'h10;
      req1_valid = 1; req1_store = 0; req1_address = 32'h14;
      for (int i = 0; i < 6; i++) begin
         cycle((i % 2 == 0) ? 2'b01 : 2'b10, "t2_rr");
         if (i % 2 == 0) begin
            if (i == 4) req0_valid = 0; else req0_address += 32'h8;
         end else begin
            if (i == 5) req1_valid = 0; else req1_address += 32'h8;
         end
      end
      cycle(2'b00, "t2_drain");

      // 3: fixed priority on the second instance
      reset_dut();
      fixed_mode = 1'b1;
      req0_valid = 1; req0_store = 1; req0_address = 32'h40;
      req0_dataWrite = 32'h1111_0000; req0_byteSelect = 4'hF;
      req1_valid = 1; req1_store = 1; req1_address = 32'h60;
      req1_dataWrite = 32'h2222_0000; req1_byteSelect = 4'hF;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("t3_fixed_req0", 96'({fx_req1_grant, fx_req0_grant}), 96'd1);
         @(posedge clk);
         #1;
         req0_address += 32'h4;
         if (i == 3) req0_valid = 0;
      end
      @(negedge clk);
      check("t3_fixed_req1", 96'({fx_req1_grant, fx_req0_grant}), 96'd2);
      @(posedge clk);
      #1;
      req1_valid = 0;
      @(negedge clk);
      fixed_mode = 1'b0;
      reset_dut();

      // 4: bus lock bounded at eight consecutive grants
      req1_valid = 1; req1_store = 1; req1_lock = 1; req1_address = 32'h80;
      req1_dataWrite = 32'h3333_0000; req1_byteSelect = 4'hF;
      cycle(2'b10, "t4_lock_first");
      req1_address += 32'h4;
      req0_valid = 1; req0_store = 1; req0_lock = 0; req0_address = 32'h28;
      req0_dataWrite = 32'h4444_0000; req0_byteSelect = 4'hF;
      for (int i = 0; i < 7; i++) begin
         cycle(2'b10, "t4_locked");
         req1_address += 32'h4;
      end
      cycle(2'b01, "t4_break");
      req0_valid = 0;
      cycle(2'b10, "t4_resume");
      req1_valid = 0; req1_lock = 0;
      cycle(2'b00, "t4_idle");

      // 5: partial store in the cycle another requester's load returns
      reset_dut();
      req1_valid = 1; req1_store = 0; req1_address = 32'h10;
      cycle(2'b10, "t5_load");
      req1_valid = 0;
      req0_valid = 1; req0_store = 1; req0_address = 32'h20;
      req0_dataWrite = 32'h0000ABCD; req0_byteSelect = 4'b0011;
      cycle(2'b01, "t5_store");
      req0_valid = 0;
      cycle(2'b00, "t5_idle");
      check("t5_mem", 96'(mem[8]), 96'(32'hC0DEABCD));

      // 6: lone requester gets every cycle
      reset_dut();
      req1_valid = 1; req1_store = 0; req1_address = 32'h0;
      for (int i = 0; i < 5; i++) begin
         cycle(2'b10, "t6_solo");
         if (i == 4) req1_valid = 0; else req1_address += 32'h4;
      end
      cycle(2'b00, "t6_drain");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
Two-requester arbiter that shares the single-ported main RAM. Requester 0 is the core's memoryController RAM-side port; requester 1 is a secondary master (frame-buffer/DMA engine). The arbiter sits between those masters and the RAM.
- Issues at most one store or load per cycle.
- Routes each one-cycle-latency RAM read back to the requester that issued it.
- Supports round-robin or fixed priority, plus a bounded bus lock for bursts.

Parameters:
DATA_WIDTH, 32, data/address width; matches the global `DATA_WIDTH.
PRIORITY_MODE, 0, 0 = round-robin, 1 = fixed priority with requester 0 winning.
MAX_LOCK_CYCLES, 8, maximum consecutive locked grants before the lock is forcibly broken for one arbitration.

Ports:
clk  in  1  clock; all state changes on posedge.
reset  in  1  asynchronous active-high reset.
reqN_valid (N=0,1)  in  1  request pending; held stable until reqN_grant.
reqN_store  in  1  1 = store, 0 = load.
reqN_address  in  DATA_WIDTH  byte address.
reqN_dataWrite  in  DATA_WIDTH  store data, already lane-aligned.
reqN_byteSelect  in  4  store byte enables.
reqN_lock  in  1  request to keep ownership for the next request.
reqN_grant  out  1  request accepted at this posedge.
reqN_readValid  out  1  reqN_dataRead holds the load result this cycle.
reqN_dataRead  out  DATA_WIDTH  load data.
ramDataRead  in  DATA_WIDTH  RAM registered read data.
addressOut  out  DATA_WIDTH  RAM address.
ramDataWrite  out  DATA_WIDTH  RAM write data.
byteSelect  out  4  RAM byte enables.
ramStore  out  1  RAM store strobe.
ramLoad  out  1  RAM load strobe.

Behaviour:
- Reset (asynchronous, active-high) values:
  - lastGrant = 1, so requester 0 wins the first tie.
  - lockActive = 0, lockCount = 0, readPending = 0.
  - All grants, readValid, ramStore and ramLoad = 0; addressOut, ramDataWrite and byteSelect = 0.
- Arbitration is combinational from the current request inputs and registered state. Zero added latency: a grant and the RAM strobe occur in the same cycle the request is presented.
- Winner selection, in priority order:
  1. lockActive, the lock owner is valid, and lockCount < MAX_LOCK_CYCLES: owner wins.
  2. Otherwise, if only one requester is valid: that requester wins.
  3. Both valid, PRIORITY_MODE = 0: the requester not equal to lastGrant wins.
  4. Both valid, PRIORITY_MODE = 1: requester 0 wins.
  5. No requester valid: idle.
- Issue:
  - The winner's grant = 1.
  - addressOut, ramDataWrite and byteSelect are driven from the winner.
  - ramStore = winner's store; ramLoad = ~winner's store.
  - byteSelect is forced to 4'b0000 on a load.
  - When idle, all RAM outputs are 0.
- The loser's grant = 0. The loser holds its request; no queueing happens inside the arbiter.
- Posedge updates on a grant:
  - lastGrant <= winner.
  - A granted load sets readPending = 1 and readOwner = winner; otherwise readPending <= 0.
- Read return: in the cycle after a granted load, reqOwner_readValid = 1 and reqOwner_dataRead = ramDataRead. The other requester's readValid = 0.
  - reqN_dataRead = ramDataRead at all times; it is valid only when readValid = 1.
  - Back-to-back loads from either requester sustain 1 load per cycle. The return of load k overlaps the issue of load k+1.
- Lock:
  - A grant with reqN_lock = 1 sets lockActive = 1, lockOwner = N, and lockCount = lockCount + 1 (counter restarts at 1 on a new owner).
  - A grant with reqN_lock = 0, or a cycle in which the lock owner is not valid, clears lockActive and lockCount.
  - When lockCount == MAX_LOCK_CYCLES, the lock is ignored for that arbitration. Normal policy applies and lockCount is cleared. The owner may re-lock on its next grant.
  - lockCount width is $clog2(MAX_LOCK_CYCLES+1).
- Boundary conditions:
  - A store grant in the cycle a read returns is legal. readValid for the earlier load still asserts.
  - If reset asserts while a read is pending, the pending read is cleared and no readValid is produced after reset; RAM data is discarded.
  - A single requester with the other idle gets 100% bandwidth regardless of lastGrant.
  - The arbiter does not check address range; range errors belong to the RAM/memoryController.
  - Deasserting reqN_valid before grant is illegal. The bench asserts this as a protocol error.

Decomposition:
- Shared defines, alongside the `DATA_WIDTH globals: ARB_ROUND_ROBIN = 0, ARB_FIXED = 1, REQ_ID_CORE = 0, REQ_ID_AUX = 1.
- One natural sub-module: arbiter_pick. It is purely combinational; inputs are valids, lastGrant, lock state and mode, and outputs are winner and idle.
- ram_arbiter keeps the request/RAM muxing, lastGrant, lock counter and readPending/readOwner registers.

Test Plan:
1. Reset mid-load: req0 load granted, reset asserted before the next posedge -> readPending = 0, no req0_readValid after reset, all RAM strobes 0.
2. Round-robin, both valid continuously with loads, PRIORITY_MODE = 0 -> grants alternate 0,1,0,1 starting with 0. Each readValid appears exactly one cycle after its grant at its owner, with correct data (addr 0x10 -> 0xDEADBEEF).
3. Fixed priority, PRIORITY_MODE = 1, both valid for 4 cycles -> req0 granted all 4 cycles, req1 granted in cycle 5 once req0 drops.
4. Lock starvation bound: req1 holds lock = 1 with continuous stores, req0 valid, MAX_LOCK_CYCLES = 8 -> req1 gets 8 consecutive grants, req0 is granted in cycle 9, then req1 resumes.
5. Store/return overlap: req0 store byteSelect = 4'b0011 data 0x0000ABCD to 0x20 in the cycle req1's prior load returns -> RAM word[0x20] low half updated, req1_readValid = 1 with correct data, req0_readValid = 0.
6. Single requester: req1 alone issues 5 back-to-back loads with lastGrant = 1 -> 5 consecutive grants and 5 consecutive readValids, no bubbles.
